// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 PC generator.
//   pc_src encodings, FSM state type/constants, mtvec MODE constant, widths.
package msrv32_pkg;

  localparam int unsigned PC_SRC_W     = 2;
  localparam int unsigned TRAP_CAUSE_W = 4;
  localparam int unsigned STATE_W      = 2;

  localparam logic [PC_SRC_W-1:0] PC_SRC_BOOT = 2'b00;
  localparam logic [PC_SRC_W-1:0] PC_SRC_EPC  = 2'b01;
  localparam logic [PC_SRC_W-1:0] PC_SRC_TRAP = 2'b10;
  localparam logic [PC_SRC_W-1:0] PC_SRC_SEQ  = 2'b11;

  typedef logic [STATE_W-1:0] pc_state_t;

  localparam pc_state_t ST_BOOT = 2'd0;
  localparam pc_state_t ST_RUN  = 2'd1;
  localparam pc_state_t ST_HOLD = 2'd2;

  // mtvec[1:0] value selecting vectored interrupt dispatch
  localparam logic [1:0] MODE_VECTORED = 2'b01;

endpackage : msrv32_pkg

// File: rtl/msrv32_trap_vec.sv
// Trap target computation from mtvec.
//   trap_base_in    : mtvec value, [1:0] = MODE
//   trap_irq_in     : trap is an interrupt
//   trap_cause_in   : interrupt cause code
//   trap_target_out : base, or base + 4*cause for vectored interrupts
module msrv32_trap_vec
  import msrv32_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]         trap_base_in,
  input  logic                    trap_irq_in,
  input  logic [TRAP_CAUSE_W-1:0] trap_cause_in,
  output logic [XLEN-1:0]         trap_target_out
);

  logic [XLEN-1:0] base_c;
  logic [XLEN-1:0] offset_c;

  always_comb begin
    base_c   = {trap_base_in[XLEN-1:2], 2'b00};
    offset_c = XLEN'({trap_cause_in, 2'b00});
    if ((trap_base_in[1:0] == MODE_VECTORED) && trap_irq_in) begin
      trap_target_out = base_c + offset_c;
    end else begin
      trap_target_out = base_c;
    end
  end

endmodule : msrv32_trap_vec

// File: rtl/msrv32_pc_gen.sv
// Program counter generator with fetch-bus redirect buffering.
//   clk_in / rst_n_in           : clock, async active-low reset
//   ahb_ready_in                : fetch bus accepts i_addr_out
//   pc_src_in                   : 00 boot, 01 epc, 10 trap, 11 seq/branch
//   branch_taken_in, iaddr_in   : branch resolution and target[XLEN-1:1]
//   epc_in                      : mret return address
//   trap_base_in/irq/cause      : trap vector inputs
//   instr_compressed_in         : 16-bit instruction (RVC builds only)
//   pc_out, pc_plus_out         : committed PC and its sequential successor
//   i_addr_out                  : fetch address
//   misaligned_instr_out        : taken branch target misaligned
//   redirect_pending_out        : redirect latched, waiting for bus ready
// Build option: MSRV32_PC_RVC_EN enables 2-byte stepping and 2-byte targets.
module msrv32_pc_gen
  import msrv32_pkg::*;
#(
  parameter int unsigned    XLEN      = 32,
  parameter logic [XLEN-1:0] BOOT_ADDR = '0
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    ahb_ready_in,
  input  logic [PC_SRC_W-1:0]     pc_src_in,
  input  logic                    branch_taken_in,
  input  logic [XLEN-2:0]         iaddr_in,
  input  logic [XLEN-1:0]         epc_in,
  input  logic [XLEN-1:0]         trap_base_in,
  input  logic                    trap_irq_in,
  input  logic [TRAP_CAUSE_W-1:0] trap_cause_in,
  input  logic                    instr_compressed_in,
  output logic [XLEN-1:0]         pc_out,
  output logic [XLEN-1:0]         pc_plus_out,
  output logic [XLEN-1:0]         i_addr_out,
  output logic                    misaligned_instr_out,
  output logic                    redirect_pending_out
);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] redirect_q, redirect_d;

  logic [XLEN-1:0] pc_step_c;
  logic [XLEN-1:0] pc_plus_c;
  logic [XLEN-1:0] branch_target_c;
  logic [XLEN-1:0] trap_target_c;
  logic [XLEN-1:0] target_c;
  logic            redirect_c;
  logic            misaligned_c;

  // Sequential step size
`ifdef MSRV32_PC_RVC_EN
  assign pc_step_c = instr_compressed_in ? XLEN'(2) : XLEN'(4);
`else
  logic rvc_unused;
  assign rvc_unused = instr_compressed_in;
  assign pc_step_c  = XLEN'(4);
`endif

  assign pc_plus_c       = pc_q + pc_step_c;
  assign branch_target_c = branch_taken_in ? {iaddr_in, 1'b0} : pc_plus_c;

  msrv32_trap_vec #(
    .XLEN (XLEN)
  ) u_trap_vec (
    .trap_base_in    (trap_base_in),
    .trap_irq_in     (trap_irq_in),
    .trap_cause_in   (trap_cause_in),
    .trap_target_out (trap_target_c)
  );

  // Target select
  always_comb begin
    target_c = branch_target_c;
    unique case (pc_src_in)
      PC_SRC_BOOT: target_c = BOOT_ADDR;
      PC_SRC_EPC:  target_c = epc_in;
      PC_SRC_TRAP: target_c = trap_target_c;
      default:     target_c = branch_target_c;
    endcase
  end

  // Anything other than plain sequential flow redirects the fetch stream
  assign redirect_c = (pc_src_in != PC_SRC_SEQ) | branch_taken_in;

  // Gated by reset so the flag is quiet while the core is held in reset
`ifdef MSRV32_PC_RVC_EN
  assign misaligned_c = 1'b0;
`else
  assign misaligned_c = rst_n_in & branch_taken_in & (pc_src_in == PC_SRC_SEQ)
                        & branch_target_c[1];
`endif

  // Next-state / datapath control
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = redirect_q;
    i_addr_out = BOOT_ADDR;

    case (state_q)
      ST_BOOT: begin
        i_addr_out = BOOT_ADDR;
        if (ahb_ready_in) begin
          pc_d    = BOOT_ADDR;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        i_addr_out = target_c;
        if (!misaligned_c) begin
          if (ahb_ready_in) begin
            pc_d = target_c;
          end else if (redirect_c) begin
            redirect_d = target_c;
            state_d    = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        i_addr_out = redirect_q;
        if (!misaligned_c) begin
          // A newer redirect supersedes the buffered one
          if (redirect_c) begin
            redirect_d = target_c;
            if (ahb_ready_in) begin
              pc_d    = target_c;
              state_d = ST_RUN;
            end
          end else if (ahb_ready_in) begin
            pc_d    = redirect_q;
            state_d = ST_RUN;
          end
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    // Boot select wins from any state and drops any buffered redirect
    if (pc_src_in == PC_SRC_BOOT) begin
      state_d    = ST_BOOT;
      redirect_d = '0;
    end
  end

  // State and PC registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_BOOT;
      pc_q       <= BOOT_ADDR;
      redirect_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
    end
  end

  assign pc_out               = pc_q;
  assign pc_plus_out          = pc_plus_c;
  assign misaligned_instr_out = misaligned_c;
  assign redirect_pending_out = (state_q == ST_HOLD);

endmodule : msrv32_pc_gen

// File: tb/tb_msrv32_pc_gen.sv
// Directed bench for msrv32_pc_gen (XLEN=32, BOOT_ADDR=0).
// Build option: MSRV32_PC_RVC_EN switches the misaligned/compressed expectations.
module tb_msrv32_pc_gen;

  logic        clk;
  logic        rst_n;
  logic        ahb_ready;
  logic [1:0]  pc_src;
  logic        branch_taken;
  logic [30:0] iaddr;
  logic [31:0] epc;
  logic [31:0] trap_base;
  logic        trap_irq;
  logic [3:0]  trap_cause;
  logic        instr_compressed;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_out;
  logic [31:0] i_addr_out;
  logic        misaligned;
  logic        pending;

  int checks   = 0;
  int failures = 0;

  msrv32_pc_gen #(
    .XLEN      (32),
    .BOOT_ADDR (32'h0)
  ) dut (
    .clk_in               (clk),
    .rst_n_in             (rst_n),
    .ahb_ready_in         (ahb_ready),
    .pc_src_in            (pc_src),
    .branch_taken_in      (branch_taken),
    .iaddr_in             (iaddr),
    .epc_in               (epc),
    .trap_base_in         (trap_base),
    .trap_irq_in          (trap_irq),
    .trap_cause_in        (trap_cause),
    .instr_compressed_in  (instr_compressed),
    .pc_out               (pc_out),
    .pc_plus_out          (pc_plus_out),
    .i_addr_out           (i_addr_out),
    .misaligned_instr_out (misaligned),
    .redirect_pending_out (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs may be changed right after return
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ahb_ready = 1'b0; pc_src = 2'b11;
    branch_taken = 1'b1; iaddr = 31'h41; epc = '0;
    trap_base = '0; trap_irq = 1'b0; trap_cause = '0; instr_compressed = 1'b0;
    #12;
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=%h", pc_out, 32'h0); end
    checks++; if (i_addr_out !== 32'h0) begin failures++; $display("FAIL rst_iaddr got=%h exp=%h", i_addr_out, 32'h0); end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL rst_pending got=%b exp=0", pending); end
    checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL rst_misaligned got=%b exp=0", misaligned); end
    tick();
    rst_n = 1'b1; branch_taken = 1'b0; iaddr = '0; ahb_ready = 1'b1;
    #1;
    checks++; if (i_addr_out !== 32'h0) begin failures++; $display("FAIL boot_iaddr got=%h exp=%h", i_addr_out, 32'h0); end
    tick();
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL boot_pc got=%h exp=%h", pc_out, 32'h0); end
    // RUN state presents the sequential target
    checks++; if (i_addr_out !== 32'h4) begin failures++; $display("FAIL run_iaddr got=%h exp=%h", i_addr_out, 32'h4); end
  endtask

  task automatic test_sequential();
    branch_taken = 1'b1; iaddr = 31'h80;
    tick();
    checks++; if (pc_out !== 32'h100) begin failures++; $display("FAIL seq_setup got=%h exp=%h", pc_out, 32'h100); end
    branch_taken = 1'b0;
    tick();
    checks++; if (pc_out !== 32'h104) begin failures++; $display("FAIL seq_pc got=%h exp=%h", pc_out, 32'h104); end
    checks++; if (pc_plus_out !== 32'h108) begin failures++; $display("FAIL seq_plus got=%h exp=%h", pc_plus_out, 32'h108); end
  endtask

  task automatic test_hold();
    ahb_ready = 1'b0; branch_taken = 1'b1; iaddr = 31'h40;
    #1;
    checks++; if (i_addr_out !== 32'h80) begin failures++; $display("FAIL hold_comb got=%h exp=%h", i_addr_out, 32'h80); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) begin branch_taken = 1'b0; iaddr = '0; end
      #1;
      checks++; if (pending !== 1'b1) begin failures++; $display("FAIL hold_pending[%0d] got=%b exp=1", i, pending); end
      checks++; if (i_addr_out !== 32'h80) begin failures++; $display("FAIL hold_iaddr[%0d] got=%h exp=%h", i, i_addr_out, 32'h80); end
      checks++; if (pc_out !== 32'h104) begin failures++; $display("FAIL hold_pc[%0d] got=%h exp=%h", i, pc_out, 32'h104); end
    end
    ahb_ready = 1'b1;
    tick();
    checks++; if (pc_out !== 32'h80) begin failures++; $display("FAIL hold_release got=%h exp=%h", pc_out, 32'h80); end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL hold_clear got=%b exp=0", pending); end
  endtask

  task automatic test_back_to_back();
    ahb_ready = 1'b0; branch_taken = 1'b1; iaddr = 31'h100;
    tick();
    checks++; if (i_addr_out !== 32'h200) begin failures++; $display("FAIL b2b_first got=%h exp=%h", i_addr_out, 32'h200); end
    iaddr = 31'h180; ahb_ready = 1'b1;
    tick();
    checks++; if (pc_out !== 32'h300) begin failures++; $display("FAIL b2b_pc got=%h exp=%h", pc_out, 32'h300); end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL b2b_pending got=%b exp=0", pending); end
    branch_taken = 1'b0;
  endtask

  task automatic test_misaligned();
    logic        exp_mis;
    logic [31:0] exp_pc;
    logic [31:0] exp_plus;
`ifdef MSRV32_PC_RVC_EN
    exp_mis = 1'b0; exp_pc = 32'h82;  exp_plus = 32'h84;
`else
    exp_mis = 1'b1; exp_pc = 32'h300; exp_plus = 32'h304;
`endif
    branch_taken = 1'b1; iaddr = 31'h41; ahb_ready = 1'b1;
    #1;
    checks++; if (misaligned !== exp_mis) begin failures++; $display("FAIL mis_flag got=%b exp=%b", misaligned, exp_mis); end
    tick();
    checks++; if (pc_out !== exp_pc) begin failures++; $display("FAIL mis_pc got=%h exp=%h", pc_out, exp_pc); end
    branch_taken = 1'b0; instr_compressed = 1'b1;
    #1;
    checks++; if (pc_plus_out !== exp_plus) begin failures++; $display("FAIL rvc_plus got=%h exp=%h", pc_plus_out, exp_plus); end
    instr_compressed = 1'b0;
  endtask

  task automatic test_trap_epc();
    pc_src = 2'b10; trap_base = 32'h1001; trap_irq = 1'b1; trap_cause = 4'd7; ahb_ready = 1'b1;
    #1;
    checks++; if (i_addr_out !== 32'h101C) begin failures++; $display("FAIL trap_vec_comb got=%h exp=%h", i_addr_out, 32'h101C); end
    tick();
    checks++; if (pc_out !== 32'h101C) begin failures++; $display("FAIL trap_vec_pc got=%h exp=%h", pc_out, 32'h101C); end
    trap_irq = 1'b0;
    #1;
    checks++; if (i_addr_out !== 32'h1000) begin failures++; $display("FAIL trap_exc_comb got=%h exp=%h", i_addr_out, 32'h1000); end
    tick();
    checks++; if (pc_out !== 32'h1000) begin failures++; $display("FAIL trap_exc_pc got=%h exp=%h", pc_out, 32'h1000); end
    trap_base = 32'h2000; trap_irq = 1'b1;
    #1;
    checks++; if (i_addr_out !== 32'h2000) begin failures++; $display("FAIL trap_direct got=%h exp=%h", i_addr_out, 32'h2000); end
    pc_src = 2'b01; epc = 32'h2468;
    #1;
    checks++; if (i_addr_out !== 32'h2468) begin failures++; $display("FAIL epc_comb got=%h exp=%h", i_addr_out, 32'h2468); end
    tick();
    checks++; if (pc_out !== 32'h2468) begin failures++; $display("FAIL epc_pc got=%h exp=%h", pc_out, 32'h2468); end
    pc_src = 2'b11; trap_irq = 1'b0;
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; iaddr = 31'h7FFF_FFFE; ahb_ready = 1'b1;
    tick();
    checks++; if (pc_out !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_setup got=%h exp=%h", pc_out, 32'hFFFF_FFFC); end
    checks++; if (pc_plus_out !== 32'h0) begin failures++; $display("FAIL wrap_plus got=%h exp=%h", pc_plus_out, 32'h0); end
    branch_taken = 1'b0;
    tick();
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=%h", pc_out, 32'h0); end
  endtask

  task automatic test_boot_force();
    tick();
    checks++; if (pc_out !== 32'h4) begin failures++; $display("FAIL bf_setup got=%h exp=%h", pc_out, 32'h4); end
    ahb_ready = 1'b0; branch_taken = 1'b1; iaddr = 31'h200;
    tick();
    checks++; if (pending !== 1'b1) begin failures++; $display("FAIL bf_hold got=%b exp=1", pending); end
    pc_src = 2'b00; branch_taken = 1'b0;
    tick();
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL bf_pending got=%b exp=0", pending); end
    pc_src = 2'b11;
    tick();
    checks++; if (i_addr_out !== 32'h0) begin failures++; $display("FAIL bf_iaddr got=%h exp=%h", i_addr_out, 32'h0); end
    checks++; if (pc_out !== 32'h4) begin failures++; $display("FAIL bf_pc_hold got=%h exp=%h", pc_out, 32'h4); end
    ahb_ready = 1'b1;
    tick();
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL bf_pc got=%h exp=%h", pc_out, 32'h0); end
    checks++; if (i_addr_out !== 32'h4) begin failures++; $display("FAIL bf_run got=%h exp=%h", i_addr_out, 32'h4); end
  endtask

  task automatic test_reset_in_hold();
    tick();
    ahb_ready = 1'b0; branch_taken = 1'b1; iaddr = 31'h300;
    tick();
    checks++; if (pending !== 1'b1) begin failures++; $display("FAIL rh_hold got=%b exp=1", pending); end
    checks++; if (pc_out !== 32'h4) begin failures++; $display("FAIL rh_pc_before got=%h exp=%h", pc_out, 32'h4); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL rh_pending got=%b exp=0", pending); end
    checks++; if (i_addr_out !== 32'h0) begin failures++; $display("FAIL rh_iaddr got=%h exp=%h", i_addr_out, 32'h0); end
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL rh_pc got=%h exp=%h", pc_out, 32'h0); end
    tick();
    branch_taken = 1'b0; rst_n = 1'b1;
    #1;
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL rh_release got=%b exp=0", pending); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hold();
    test_back_to_back();
    test_misaligned();
    test_trap_epc();
    test_wrap();
    test_boot_force();
    test_reset_in_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_msrv32_pc_gen
